// File: rtl/sipo_load_ctrl.sv
// sipo_load_ctrl: serializes a parallel word into an external SIPO shift
// register at a divided bit rate, then pulses a latch so the outputs update.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_data     : WIDTH-bit word to serialize
//   in_valid    : requester offers in_data
//   in_ready    : controller is idle and will accept in_valid
//   abort       : cancels a load in progress (ignored while idle)
//   sr_data     : serial bit to the shift register
//   sr_shift    : shift enable, sampled downstream at the end of the cycle
//   sr_latch    : one-cycle transfer pulse to the parallel outputs
//   busy        : load in progress (SHIFT or LATCH)
//   done        : one-cycle completion pulse, coincident with sr_latch
module sipo_load_ctrl #(
   parameter int WIDTH     = 8,
   parameter int CLK_DIV   = 5,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             abort,
   output logic             sr_data,
   output logic             sr_shift,
   output logic             sr_latch,
   output logic             busy,
   output logic             done
);

   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_LATCH
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  shadow_q, shadow_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [DW-1:0]     div_q, div_d;

   logic              head_bit;
   logic              period_end;
   logic [WIDTH-1:0]  shadow_adv;

   // Head of the shadow is the bit currently on the serial line; advancing
   // moves the next bit into the head position.
   assign head_bit   = MSB_FIRST ? shadow_q[WIDTH-1] : shadow_q[0];
   assign period_end = (div_q == DIV_LAST);
   assign shadow_adv = MSB_FIRST ? {shadow_q[WIDTH-2:0], 1'b0}
                                 : {1'b0, shadow_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shadow_q <= '0;
         bit_q    <= '0;
         div_q    <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      bit_d    = bit_q;
      div_d    = div_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shadow_d = in_data;
               bit_d    = '0;
               div_d    = '0;
               state_d  = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               bit_d   = '0;
               div_d   = '0;
               state_d = S_IDLE;
            end else if (period_end) begin
               shadow_d = shadow_adv;
               div_d    = '0;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = S_LATCH;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_LATCH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are state-decoded; the only input dependence is abort
   // suppressing the latch pulse so a cancelled load is never latched.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      sr_data  = 1'b0;
      sr_shift = 1'b0;
      sr_latch = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
         end
         S_SHIFT: begin
            busy     = 1'b1;
            sr_data  = head_bit;
            sr_shift = period_end;
         end
         S_LATCH: begin
            busy     = 1'b1;
            sr_latch = !abort;
            done     = !abort;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// tb_sipo_load_ctrl: bench for sipo_load_ctrl, two instances (defaults and
// LSB-first with CLK_DIV=1) checked against a cycle-count model every cycle.
module tb_sipo_load_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iv [2];
   logic       ab [2];
   logic [7:0] id [2];
   logic       rdy [2];
   logic       bsy [2];
   logic       sd [2];
   logic       ss [2];
   logic       sl [2];
   logic       dn [2];

   int total = 0;
   int bad = 0;

   sipo_load_ctrl #(.WIDTH(8), .CLK_DIV(5), .MSB_FIRST(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .in_data(id[0]), .in_valid(iv[0]),
      .in_ready(rdy[0]), .abort(ab[0]), .sr_data(sd[0]),
      .sr_shift(ss[0]), .sr_latch(sl[0]), .busy(bsy[0]), .done(dn[0])
   );

   sipo_load_ctrl #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .in_data(id[1]), .in_valid(iv[1]),
      .in_ready(rdy[1]), .abort(ab[1]), .sr_data(sd[1]),
      .sr_shift(ss[1]), .sr_latch(sl[1]), .busy(bsy[1]), .done(dn[1])
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Model: t = cycles since accept (0 = idle), w = captured word.
   int         t [2];
   logic [7:0] w [2];
   logic [7:0] sipo [2] = '{8'h00, 8'h00};
   logic [7:0] latv [2] = '{8'h00, 8'h00};
   int         cyc = 0;
   int         acc_at [2];
   int         acc_n [2];
   int         acc_log [2][64];
   int         lat_n [2];
   logic [7:0] lat_log [2][64];
   int         lat_rel [2][64];
   int         sh_n [2];
   logic       sh_bit [2][512];
   int         sh_rel [2][512];

   function automatic int divof(input int i);
      return (i == 0) ? 5 : 1;
   endfunction

   function automatic logic [5:0] expv(input int i);
      int   d;
      int   k;
      logic b;
      logic s;
      d = divof(i);
      if (t[i] == 0) return 6'b100000;
      if (t[i] <= 8 * d) begin
         k = (t[i] - 1) / d;
         b = (i == 0) ? w[i][7 - k] : w[i][k];
         s = ((t[i] % d) == 0);
         return {1'b0, 1'b1, b, s, 1'b0, 1'b0};
      end
      return {1'b0, 1'b1, 1'b0, 1'b0, !ab[i], !ab[i]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t[0] = 0;
         t[1] = 0;
      end else begin
         cyc++;
         for (int i = 0; i < 2; i++) begin
            if (ss[i]) begin
               sipo[i] = (i == 0) ? {sipo[i][6:0], sd[i]}
                                  : {sd[i], sipo[i][7:1]};
               if (sh_n[i] < 512) begin
                  sh_bit[i][sh_n[i]] = sd[i];
                  sh_rel[i][sh_n[i]] = cyc - acc_at[i];
               end
               sh_n[i]++;
            end
            if (sl[i]) begin
               latv[i] = sipo[i];
               if (lat_n[i] < 64) begin
                  lat_log[i][lat_n[i]] = sipo[i];
                  lat_rel[i][lat_n[i]] = cyc - acc_at[i];
               end
               lat_n[i]++;
            end
            if (t[i] == 0) begin
               if (iv[i]) begin
                  t[i] = 1;
                  w[i] = id[i];
                  acc_at[i] = cyc;
                  if (acc_n[i] < 64) acc_log[i][acc_n[i]] = cyc;
                  acc_n[i]++;
               end
            end else if (ab[i] || t[i] == 8 * divof(i) + 1) begin
               t[i] = 0;
            end else begin
               t[i]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("u0_outs", {26'd0, rdy[0], bsy[0], sd[0], ss[0], sl[0], dn[0]},
          {26'd0, expv(0)});
      chk("u1_outs", {26'd0, rdy[1], bsy[1], sd[1], ss[1], sl[1], dn[1]},
          {26'd0, expv(1)});
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      int         b0, b1, a0, l0, l1;
      logic [7:0] v0, v1, r;
      logic [7:0] pat0;
      logic       ord1 [8];
      pat0 = 8'hA5;
      ord1 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0;
         ab[i] = 1'b0;
         id[i] = 8'h00;
      end
      #3;
      chk("rst_ready", rdy[0], 1);
      chk("rst_busy", bsy[0], 0);
      #14 rst_n = 1'b1;
      tick(1);

      // Single load on both instances
      b0 = sh_n[0]; b1 = sh_n[1]; l0 = lat_n[0]; l1 = lat_n[1];
      iv[0] = 1'b1; id[0] = 8'hA5;
      iv[1] = 1'b1; id[1] = 8'h3C;
      tick(1);
      iv[0] = 1'b0; iv[1] = 1'b0;
      id[0] = 8'($urandom); id[1] = 8'($urandom);
      tick(8);
      chk("u1_latch_c9", sl[1], 1);
      chk("u1_done_c9", dn[1], 1);
      tick(1);
      chk("u1_ready_c10", rdy[1], 1);
      tick(36);
      chk("u0_nshift", sh_n[0] - b0, 8);
      for (int k = 0; k < 8; k++) begin
         chk("u0_bit", sh_bit[0][b0 + k], pat0[7 - k]);
         chk("u0_shift_cyc", sh_rel[0][b0 + k], 5 * (k + 1));
         chk("u1_bit", sh_bit[1][b1 + k], ord1[k]);
         chk("u1_shift_cyc", sh_rel[1][b1 + k], k + 1);
      end
      chk("u0_nlatch", lat_n[0] - l0, 1);
      chk("u0_latch_cyc", lat_rel[0][l0], 41);
      chk("u0_latched", latv[0], 8'hA5);
      chk("u1_nshift", sh_n[1] - b1, 8);
      chk("u1_latch_cyc", lat_rel[1][l1], 9);
      chk("u1_latched", latv[1], 8'h3C);

      // Back-to-back with in_valid held, data wiggling while busy
      a0 = acc_n[0]; l0 = lat_n[0];
      iv[0] = 1'b1; id[0] = 8'h01;
      tick(1);
      for (int c = 0; c < 20; c++) begin
         id[0] = 8'($urandom);
         tick(1);
      end
      id[0] = 8'hFF;
      tick(70);
      iv[0] = 1'b0;
      tick(50);
      chk("b2b_gap", acc_log[0][a0 + 1] - acc_log[0][a0], 42);
      chk("b2b_first", lat_log[0][l0], 8'h01);
      chk("b2b_second", lat_log[0][l0 + 1], 8'hFF);

      // Abort after the third shift pulse
      l0 = lat_n[0]; v0 = latv[0]; b0 = sh_n[0];
      iv[0] = 1'b1; id[0] = 8'h81;
      tick(1);
      iv[0] = 1'b0;
      for (int c = 0; c < 60 && (sh_n[0] - b0) < 3; c++) tick(1);
      chk("abort_at_3", sh_n[0] - b0, 3);
      ab[0] = 1'b1;
      tick(1);
      ab[0] = 1'b0;
      chk("abort_ready", rdy[0], 1);
      tick(45);
      chk("abort_nlatch", lat_n[0] - l0, 0);
      chk("abort_latv", latv[0], v0);
      iv[0] = 1'b1; id[0] = 8'h42;
      tick(1);
      iv[0] = 1'b0;
      tick(45);
      chk("after_abort", latv[0], 8'h42);

      // Asynchronous reset mid-shift
      l0 = lat_n[0]; l1 = lat_n[1];
      iv[0] = 1'b1; id[0] = 8'hC3;
      iv[1] = 1'b1; id[1] = 8'hC3;
      tick(1);
      iv[0] = 1'b0; iv[1] = 1'b0;
      tick(12);
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("arst_ready", rdy[i], 1);
         chk("arst_busy", bsy[i], 0);
         chk("arst_shift", ss[i], 0);
         chk("arst_data", sd[i], 0);
      end
      #2 rst_n = 1'b1;
      tick(1);
      chk("arst_nolatch0", lat_n[0] - l0, 0);
      iv[0] = 1'b1; id[0] = 8'h5A;
      iv[1] = 1'b1; id[1] = 8'h5A;
      tick(1);
      iv[0] = 1'b0; iv[1] = 1'b0;
      tick(50);
      chk("arst_u0_5a", latv[0], 8'h5A);
      chk("arst_u1_5a", latv[1], 8'h5A);

      // Abort coincident with the latch cycle, then accept under abort
      l0 = lat_n[0]; v0 = latv[0];
      r = 8'($urandom);
      iv[0] = 1'b1; id[0] = r;
      tick(1);
      iv[0] = 1'b0;
      tick(40);
      ab[0] = 1'b1;
      #1;
      chk("latch_abort_sl", sl[0], 0);
      chk("latch_abort_dn", dn[0], 0);
      chk("latch_abort_busy", bsy[0], 1);
      tick(1);
      chk("latch_abort_idle", rdy[0], 1);
      chk("latch_abort_latv", latv[0], v0);
      v1 = 8'($urandom);
      iv[0] = 1'b1; id[0] = v1;
      tick(1);
      chk("idle_abort_accept", bsy[0], 1);
      ab[0] = 1'b0; iv[0] = 1'b0;
      tick(45);
      chk("idle_abort_latv", latv[0], v1);
      chk("idle_abort_nlatch", lat_n[0] - l0, 1);

      // Random traffic, checked cycle by cycle by the compare process
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 2; i++) begin
            iv[i] = ($urandom % 4) == 0;
            id[i] = 8'($urandom);
            ab[i] = ($urandom % 40) == 0;
         end
         tick(1);
      end
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0;
         ab[i] = 1'b0;
      end
      tick(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
